// File: rtl/glbl_reset_pkg.sv
// glbl_reset_pkg: shared types and constants for the global reset sequencer.
//   state_e        - sequencer FSM states
//   RocDefault     - power-on GSR/PRLD hold length (cycles)
//   TocDefault     - power-on extra GTS hold length (cycles)
//   HoldoffDefault - quiet cycles after GTS release before the next grant
//   onehot_to_idx  - index of the set bit in a one-hot vector (up to 8 bits)
package glbl_reset_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAssert,
        StGtsHold,
        StHoldoff,
        StDone
    } state_e;

    localparam int unsigned RocDefault     = 16;
    localparam int unsigned TocDefault     = 4;
    localparam int unsigned HoldoffDefault = 8;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin selector for the reset requesters.
//   clk, rst   - clock, asynchronous active-high reset
//   pending_i  - latched requests awaiting service
//   advance_i  - a grant is being taken this cycle; move the pointer to the winner
//   grant_o    - one-hot winner (combinational), zero when nothing is pending
//   last_o     - index of the most recent winner
module rr_arbiter
    import glbl_reset_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IdxW-1:0]    last_o
);

    logic [IdxW-1:0] last_q;
    logic            found;

    // Search starts one past the last winner and wraps; the reset value of the
    // pointer makes index 0 the first candidate.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int unsigned o = 1; o <= NUM_REQ; o++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!found && pending_i[j] && (j == (32'(last_q) + o) % NUM_REQ)) begin
                    grant_o[j] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IdxW'(NUM_REQ - 1);
        end else if (advance_i && found) begin
            last_q <= IdxW'(onehot_to_idx(8'(grant_o)));
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/glbl_reset_sequencer.sv
// glbl_reset_sequencer: drives the global GSR/GTS/PRLD strobes through an
// ordered, cycle-counted release and shares that sequence between requesters.
//   clk, rst            - clock, asynchronous active-high reset (runs power-on sequence)
//   req_i               - single-cycle request pulses, one per requester
//   roc_cfg_i/toc_cfg_i - GSR/PRLD hold and extra GTS hold, captured at grant
//   gsr_o/gts_o/prld_o  - global strobes
//   grant_o             - one-hot owner of the running sequence (zero for power-on)
//   busy_o/done_o       - sequence in progress / one-cycle completion pulse
//   pending_o           - requests latched but not yet served
module glbl_reset_sequencer
    import glbl_reset_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned ROC_DEFAULT = RocDefault,
    parameter int unsigned TOC_DEFAULT = TocDefault,
    parameter int unsigned HOLDOFF     = HoldoffDefault,
    localparam int unsigned IdxW       = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [CNT_W-1:0]   roc_cfg_i,
    input  logic [CNT_W-1:0]   toc_cfg_i,
    output logic               gsr_o,
    output logic               gts_o,
    output logic               prld_o,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [NUM_REQ-1:0] pending_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   toc_q, toc_d;
    logic [NUM_REQ-1:0] req_q;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               gsr_q, gsr_d, gts_q, gts_d, busy_q, busy_d, done_q, done_d;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IdxW-1:0]    arb_last;
    logic               advance;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .pending_i (pending_q),
        .advance_i (advance),
        .grant_o   (arb_grant),
        .last_o    (arb_last)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        toc_d   = toc_q;
        advance = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (|pending_q) begin
                    // Start the next sequence straight away; a zero ROC still
                    // gives a one-cycle GSR.
                    advance = 1'b1;
                    state_d = StAssert;
                    cnt_d   = (roc_cfg_i == '0) ? CNT_W'(1) : roc_cfg_i;
                    toc_d   = toc_cfg_i;
                end else begin
                    state_d = StIdle;
                end
            end
            StAssert: begin
                if (cnt_q <= CNT_W'(1)) begin
                    if (toc_q == '0) begin
                        state_d = StHoldoff;
                        cnt_d   = CNT_W'(HOLDOFF);
                    end else begin
                        state_d = StGtsHold;
                        cnt_d   = toc_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StGtsHold: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = StHoldoff;
                    cnt_d   = CNT_W'(HOLDOFF);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StHoldoff: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // OR-ing after the clear means a request landing on its own grant edge
        // is kept for another round.
        pending_d = (pending_q & ~(advance ? arb_grant : '0)) | req_q;

        // Outputs are registered copies of what the next state implies.
        gsr_d   = (state_d == StAssert);
        gts_d   = (state_d == StAssert) || (state_d == StGtsHold);
        busy_d  = gts_d || (state_d == StHoldoff);
        done_d  = (state_d == StDone);
        if (advance) begin
            grant_d = arb_grant;
        end else if (busy_d) begin
            grant_d = grant_q;
        end else begin
            grant_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StAssert;
            cnt_q     <= CNT_W'(ROC_DEFAULT);
            toc_q     <= CNT_W'(TOC_DEFAULT);
            req_q     <= '0;
            pending_q <= '0;
            grant_q   <= '0;
            gsr_q     <= 1'b1;
            gts_q     <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            toc_q     <= toc_d;
            // Request pulses are registered once before merging into pending,
            // giving two edges from a sampled request to GSR rising.
            req_q     <= req_i;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            gsr_q     <= gsr_d;
            gts_q     <= gts_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The arbiter pointer always names the owner of a requester sequence.
    assert property (@(posedge clk) disable iff (rst)
        (|grant_q) |-> (IdxW'(onehot_to_idx(8'(grant_q))) == arb_last));

    assign gsr_o     = gsr_q;
    assign prld_o    = gsr_q;
    assign gts_o     = gts_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign grant_o   = grant_q;
    assign pending_o = pending_q;

endmodule
